// File: rtl/mole_scheduler.sv
// Whack-a-mole sequencer: alternates dark gaps with a single lit mole at an
// LFSR-chosen position, scores edge-detected presses and ends after MAX_MISSES misses.
module mole_scheduler #(
    parameter int unsigned N_MOLES    = 8,
    parameter int unsigned UP_TICKS   = 50,
    parameter int unsigned GAP_TICKS  = 20,
    parameter int unsigned MAX_MISSES = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               start,
    input  logic [N_MOLES-1:0] btn,
    output logic [N_MOLES-1:0] leds,
    output logic [7:0]         score,
    output logic [3:0]         misses,
    output logic               hit,
    output logic               miss,
    output logic               game_over
);

    localparam int unsigned PosW = (N_MOLES > 1) ? $clog2(N_MOLES) : 1;
    localparam logic [7:0] PosMask = 8'(N_MOLES - 1);
    localparam logic [7:0] GapLast = 8'(GAP_TICKS - 1);
    localparam logic [7:0] UpLast  = 8'(UP_TICKS - 1);
    localparam logic [3:0] MaxMiss = 4'(MAX_MISSES);
    localparam logic [N_MOLES-1:0] OneHot0 = N_MOLES'(1);

    typedef enum logic [1:0] {StIdle, StGap, StUp, StOver} state_e;

    state_e             state_q;
    logic [7:0]         count_q;
    logic [7:0]         lfsr_q;
    logic [N_MOLES-1:0] btn_q;
    logic [PosW-1:0]    pos_q;

    logic [N_MOLES-1:0] press;
    logic [N_MOLES-1:0] pos_mask;
    logic               press_hit;
    logic               press_wrong;
    logic               up_timeout;
    logic               lfsr_fb;
    logic [3:0]         misses_inc;
    logic [PosW-1:0]    new_pos;

    always_comb begin
        press       = btn & ~btn_q;
        pos_mask    = OneHot0 << pos_q;
        press_hit   = |(press & pos_mask);
        press_wrong = |(press & ~pos_mask);
        up_timeout  = tick && (count_q == UpLast);
        // x^8 + x^6 + x^5 + x^4 + 1, shifting towards the MSB
        lfsr_fb     = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
        misses_inc  = misses + 4'd1;
        new_pos     = PosW'(lfsr_q & PosMask);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            count_q   <= 8'd0;
            lfsr_q    <= 8'hA5;
            btn_q     <= '0;
            pos_q     <= '0;
            leds      <= '0;
            score     <= 8'd0;
            misses    <= 4'd0;
            hit       <= 1'b0;
            miss      <= 1'b0;
            game_over <= 1'b0;
        end else begin
            lfsr_q <= {lfsr_q[6:0], lfsr_fb};
            btn_q  <= btn;
            hit    <= 1'b0;
            miss   <= 1'b0;
            unique case (state_q)
                StIdle, StOver: begin
                    if (start) begin
                        state_q   <= StGap;
                        count_q   <= 8'd0;
                        score     <= 8'd0;
                        misses    <= 4'd0;
                        leds      <= '0;
                        game_over <= 1'b0;
                    end
                end
                StGap: begin
                    if (tick) begin
                        if (count_q == GapLast) begin
                            state_q <= StUp;
                            count_q <= 8'd0;
                            pos_q   <= new_pos;
                            leds    <= OneHot0 << new_pos;
                        end else begin
                            count_q <= count_q + 8'd1;
                        end
                    end
                end
                StUp: begin
                    // Correct press beats a wrong press, which beats the timeout
                    if (press_hit) begin
                        hit     <= 1'b1;
                        state_q <= StGap;
                        count_q <= 8'd0;
                        leds    <= '0;
                        if (score != 8'hFF) begin
                            score <= score + 8'd1;
                        end
                    end else if (press_wrong || up_timeout) begin
                        miss    <= 1'b1;
                        misses  <= misses_inc;
                        count_q <= 8'd0;
                        if (misses_inc == MaxMiss) begin
                            state_q   <= StOver;
                            leds      <= '1;
                            game_over <= 1'b1;
                        end else begin
                            state_q <= StGap;
                            leds    <= '0;
                        end
                    end else if (tick) begin
                        count_q <= count_q + 8'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/mole_scheduler.md
MOLE_SCHEDULER -- requirements
Module: mole_scheduler

Interface
REQ-001 Parameter N_MOLES, default 8: number of mole positions, one LED and one button each; fixed at a power of two, max 8.
REQ-002 Parameter UP_TICKS, default 50: ticks a mole stays lit (50 x 10 ms = 500 ms).
REQ-003 Parameter GAP_TICKS, default 20: ticks of dark gap between moles.
REQ-004 Parameter MAX_MISSES, default 3: misses that end the game (1..15).
REQ-005 clk  input  1  system clock, 100 MHz.
REQ-006 rst  input  1  reset; asynchronous, active-high.
REQ-007 tick  input  1  single-cycle time-base strobe, one every 10 ms, from the tick counter.
REQ-008 start  input  1  level; a new game starts when this is sampled high in IDLE or OVER.
REQ-009 btn  input  N_MOLES  debounced, clk-synchronous button levels, active-high.
REQ-010 leds  output  N_MOLES  mole display, one-hot while a mole is up.
REQ-011 score  output  8  hits in the current game.
REQ-012 misses  output  4  misses in the current game.
REQ-013 hit  output  1  one-cycle pulse per successful whack.
REQ-014 miss  output  1  one-cycle pulse per miss.
REQ-015 game_over  output  1  high while in OVER.

Function
REQ-016 FSM states: IDLE, GAP, UP, OVER; all outputs registered.
REQ-017 IDLE: leds=0. If start=1 -> GAP, score=0, misses=0, tick count=0.
REQ-018 Tick count: 8-bit; cleared on every state entry; increments only on cycles with tick=1.
REQ-019 GAP: leds=0. On a tick cycle with count==GAP_TICKS-1 -> UP.
REQ-020 On the GAP->UP transition, latch pos=lfsr[log2(N_MOLES)-1:0]; during UP, leds=1<<pos.
REQ-021 LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1; shifts every clk cycle in every state; reset seed 8'hA5; never all-zero.
REQ-022 Edge detect: btn_q registers btn every cycle; press = btn & ~btn_q.
REQ-023 UP, press[pos]=1 -> hit=1 next cycle, score+1 saturating at 255, -> GAP.
REQ-024 UP, press on any other bit with press[pos]=0 -> miss=1, misses+1, leave UP.
REQ-025 UP, tick cycle with count==UP_TICKS-1 and no press[pos] -> miss=1, misses+1, leave UP.
REQ-026 On a miss: if the new misses value == MAX_MISSES -> OVER, else -> GAP.
REQ-027 Priority in UP on the same cycle: press[pos] > wrong press > timeout; exactly one of hit/miss pulses.
REQ-028 Presses during IDLE, GAP and OVER are ignored; they have no effect on score or misses.
REQ-029 OVER: leds=all ones, game_over=1; score and misses hold. start=1 -> GAP with clears as in REQ-017.
REQ-030 start is ignored in GAP and UP.
REQ-031 tick is only counted in GAP and UP; a tick arriving in the same cycle as a state change is not counted in the new state.

Reset
REQ-032 rst=1 forces asynchronously: state=IDLE, leds=0, score=0, misses=0, hit=0, miss=0, game_over=0, count=0, btn_q=0, lfsr=8'hA5.
REQ-033 Reset mid-game discards the game; the first edge after release is evaluated from IDLE.

Verification (bench parameters: UP_TICKS=4, GAP_TICKS=2, MAX_MISSES=3, tick every 5 clk)
REQ-034 Stimulus: reset, then start pulse. Required response: GAP, then UP after 2 ticks; leds one-hot equal to 1<<lfsr[2:0] at the transition; score=0.
REQ-035 Stimulus: raise btn[pos] in UP. Required response: hit pulse of exactly 1 cycle, score=1, leds=0 (GAP) next cycle. Holding btn gives no second hit.
REQ-036 Stimulus: no press for 4 ticks in UP, three times. Required response: three miss pulses, misses=3, OVER, leds=8'hFF, game_over=1.
REQ-037 Stimulus: wrong button and correct button edges in the same cycle. Required response: hit=1, miss=0. Stimulus: press[pos] on the timeout tick. Required response: hit wins.
REQ-038 Stimulus: drive 256 hits. Required response: score saturates at 255. Then start in OVER: score=0, misses=0, state GAP.
REQ-039 Stimulus: assert rst asynchronously (between clk edges) during UP. Required response: leds=0, score=0, misses=0 immediately, without waiting for a clk edge.
